audio_i2s_capture: RTL and testbench
====================================

// Module: audio_i2s_capture
// PURPOSE
//  Captures serial ADC audio (BCLK, ADCLRCK, ADCDAT) from the codec. Assembles signed stereo
//  sample pairs and buffers them in a small FIFO. Presents them on an Avalon-ST source to the
//  audio interface of the NIOS II system. Sits directly upstream of the audio_interface conduit;
//  runs entirely in the system clock domain.
// PARAMETERS
//  DATA_WIDTH  16  bits kept per channel sample (8..32)
//  FIFO_DEPTH  8   stereo frames buffered; power of 2, >=2
//  I2S_MODE    1   1 = I2S (MSB one BCLK after LRCK edge); 0 = left-justified (MSB on LRCK edge)
// PORTS
//  clk_clk        in   1             system clock; must be >= 4x BCLK
//  reset_reset_n  in   1             synchronous active-low reset
//  adc_bclk       in   1             codec bit clock, async
//  adc_lrck       in   1             codec LR clock, async; 0 = left, 1 = right
//  adc_dat        in   1             codec serial data, async, MSB first
//  src_data       out  2*DATA_WIDTH  {left,right} of FIFO head
//  src_valid      out  1             FIFO not empty
//  src_ready      in   1             sink accepts head this cycle
//  overflow       out  1             sticky: frame dropped because FIFO full
//  overflow_clr   in   1             clears overflow
//  peak_clr       in   1             clears peak registers (PEAK_METER_EN only)
//  peak_left      out  DATA_WIDTH    left |sample| maximum (PEAK_METER_EN only)
//  peak_right     out  DATA_WIDTH    right |sample| maximum (PEAK_METER_EN only)
// BEHAVIOUR
//  - Reset values: src_valid=0, src_data=0, overflow=0, peaks=0, FIFO empty, FSM=IDLE.
//  - Synchronisation: 2-FF synchroniser on bclk, lrck, dat. Work happens only on a detected
//    BCLK rising edge (1-clk strobe); lrck and dat are sampled at that strobe.
//  - Channel switch: synced lrck differs from the stored lrck at a strobe.
//  - FSM:
//    IDLE  -> wait for a lrck 1->0 switch (start of left) -> SKIP if I2S_MODE else SHIFT.
//    SKIP  -> the bit at the switch strobe is ignored -> SHIFT at the next strobe.
//    SHIFT -> shift dat MSB first; after DATA_WIDTH bits -> HOLD.
//    HOLD  -> ignore extra slot bits (e.g. 24/32-bit slot keeps top DATA_WIDTH).
//  - Word completion: on every switch, the current word completes. If fewer than DATA_WIDTH
//    bits were shifted, the missing LSBs are zero-filled.
//  - 0->1 switch: latch left word, start right word.
//  - 1->0 switch: push {left,right} to the FIFO, start the next left word.
//  - Partial first frame after reset or IDLE is never pushed.
//  - FIFO:
//    push-to-src_valid latency 1 clk. Head is registered (show-ahead). Pop on src_valid&&src_ready.
//    Full and push without pop: frame dropped, overflow<=1.
//    Full and push with pop in the same cycle: push accepted.
//    Empty and push: src_valid rises next clk; a same-cycle pop is not possible.
//    Pointers wrap modulo FIFO_DEPTH.
//  - overflow_clr and a new drop in the same cycle: set wins.
//  - Reset mid-operation: partial words and FIFO contents are discarded; FSM returns to IDLE and
//    resynchronises on the next lrck 1->0.
// CONFIGURATION
//  PEAK_METER_EN defined:
//    On each accepted push, peak_x <= max(peak_x, |sample_x|) (two's complement).
//    |most-negative| saturates to the max positive value.
//    peak_clr zeroes both peaks; a same-cycle update is applied after the clear.
//  PEAK_METER_EN undefined:
//    peak_left/peak_right tied to 0, peak_clr ignored, no peak logic.
// TESTING
//  1 DATA_WIDTH=16, I2S_MODE=1, BCLK=clk/8, L=0x1234, R=0xABCD -> src_data=0x1234ABCD;
//    src_valid 1 clk after the lrck 1->0 strobe.
//  2 src_ready=0, 9 frames at FIFO_DEPTH=8 -> frames 1..8 pop in order, frame 9 lost, overflow=1;
//    pulse overflow_clr -> overflow=0.
//  3 Stream starts mid-right channel after reset -> no partial frame output; first output is the
//    first complete L/R pair.
//  4 32-bit slot L=0x89ABCDEF -> left=0x89AB; 12-bit slot L=0xABC -> left=0xABC0.
//  5 reset_reset_n low for 1 clk mid-left word with 3 frames queued -> src_valid=0 next clk;
//    the next full frame outputs correctly.
//  6 PEAK_METER_EN, left samples 0x0100 then 0x8000 -> peak_left=0x7FFF; peak_clr -> 0.

Source files
------------

// File: rtl/audio_i2s_capture_if.sv
// rtl/audio_i2s_capture_if.sv - Avalon-ST style stereo sample stream between capture and sink
interface audio_i2s_capture_if #(
  parameter int DATA_WIDTH = 16
);
  logic [2*DATA_WIDTH-1:0] src_data;
  logic                    src_valid;
  logic                    src_ready;

  modport master (output src_data, output src_valid, input src_ready);
  modport slave  (input src_data, input src_valid, output src_ready);
endinterface

// File: rtl/audio_i2s_capture.sv
// rtl/audio_i2s_capture.sv - I2S/left-justified ADC capture into a stereo frame FIFO; PEAK_METER_EN adds peak meters
module audio_i2s_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int I2S_MODE   = 1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  adc_bclk,
  input  logic                  adc_lrck,
  input  logic                  adc_dat,
  audio_i2s_capture_if.master   src,
  output logic                  overflow,
  input  logic                  overflow_clr,
  input  logic                  peak_clr,
  output logic [DATA_WIDTH-1:0] peak_left,
  output logic [DATA_WIDTH-1:0] peak_right
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, HOLD} state_t;

  logic [1:0] bclk_sync, lrck_sync, dat_sync;
  logic       bclk_prev;
  logic       strobe, lrck_s, dat_s, sw;

  state_t          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d, left_q, left_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lrck_q, lrck_d;
  logic [W-1:0]    sr_shift, fin_sr, word;
  logic [CW-1:0]   fin_cnt;
  logic            push;
  logic [2*W-1:0]  push_data;

  logic [2*W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q, rptr_n;
  logic [NW-1:0]   count_q, count_n;
  logic            valid_q, overflow_q;
  logic [2*W-1:0]  data_q, head_n;
  logic            pop, full, push_ok, drop;

  // Two-flop synchronisers for the codec pins plus BCLK history for edge detect
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], adc_bclk};
      lrck_sync <= {lrck_sync[0], adc_lrck};
      dat_sync  <= {dat_sync[0], adc_dat};
      bclk_prev <= bclk_sync[1];
    end
  end

  assign strobe   = bclk_sync[1] & ~bclk_prev;
  assign lrck_s   = lrck_sync[1];
  assign dat_s    = dat_sync[1];
  assign sw       = lrck_s != lrck_q;
  assign sr_shift = {sr_q[W-2:0], dat_s};

  // Deserialiser state register
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      lrck_q  <= 1'b0;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      lrck_q  <= lrck_d;
      left_q  <= left_d;
    end
  end

  // Next-state: shift bits at each BCLK strobe, close the word on every LRCK switch
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    lrck_d  = lrck_q;
    left_d  = left_q;
    push    = 1'b0;
    // In I2S the bit at the switch strobe is the LSB of the word being closed
    if ((I2S_MODE != 0) && (state_q == SHIFT)) begin
      fin_sr  = sr_shift;
      fin_cnt = cnt_q + 1'b1;
    end else begin
      fin_sr  = sr_q;
      fin_cnt = cnt_q;
    end
    // Left-align the completed bits; missing LSBs become zero
    word      = fin_sr << (CW'(W) - fin_cnt);
    push_data = {left_q, word};
    if (strobe) begin
      lrck_d = lrck_s;
      if (sw && ((state_q != IDLE) || lrck_q)) begin
        if (state_q != IDLE) begin
          if (!lrck_q) begin
            left_d = word;
          end else begin
            push = 1'b1;
          end
        end
        if (I2S_MODE != 0) begin
          sr_d    = '0;
          cnt_d   = '0;
          state_d = SKIP;
        end else begin
          sr_d    = {{(W-1){1'b0}}, dat_s};
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end else if (!sw) begin
        unique case (state_q)
          SKIP: begin
            sr_d    = sr_shift;
            cnt_d   = CW'(1);
            state_d = SHIFT;
          end
          SHIFT: begin
            sr_d  = sr_shift;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(W - 1)) state_d = HOLD;
          end
          default: ;
        endcase
      end
    end
  end

  assign pop     = valid_q & src.src_ready;
  assign full    = count_q == NW'(FIFO_DEPTH);
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // FIFO pointer/occupancy next values and the show-ahead head
  always_comb begin
    rptr_n = pop ? rptr_q + 1'b1 : rptr_q;
    unique case ({push_ok, pop})
      2'b10:   count_n = count_q + 1'b1;
      2'b01:   count_n = count_q - 1'b1;
      default: count_n = count_q;
    endcase
    head_n = data_q;
    if (count_n != '0) begin
      // Pushing into an empty (post-pop) FIFO: forward the incoming frame
      if (push_ok && (wptr_q == rptr_n)) head_n = push_data;
      else                               head_n = mem[rptr_n];
    end
  end

  // Frame storage; contents are don't-care until a pointer covers them
  always_ff @(posedge clk_clk) begin
    if (push_ok) mem[wptr_q] <= push_data;
  end

  // FIFO control, registered head and sticky overflow (a new drop beats clear)
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      rptr_q  <= rptr_n;
      count_q <= count_n;
      valid_q <= count_n != '0;
      data_q  <= head_n;
      if (drop)              overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  assign src.src_data  = data_q;
  assign src.src_valid = valid_q;
  assign overflow      = overflow_q;

`ifdef PEAK_METER_EN
  logic [W-1:0] peak_l_q, peak_r_q, peak_l_d, peak_r_d, abs_l, abs_r;

  function automatic logic [W-1:0] abs_sat(input logic [W-1:0] s);
    if (!s[W-1]) return s;
    if (s == {1'b1, {(W-1){1'b0}}}) return {1'b0, {(W-1){1'b1}}};
    return -s;
  endfunction

  assign abs_l = abs_sat(push_data[2*W-1:W]);
  assign abs_r = abs_sat(push_data[W-1:0]);

  // Clear first, then fold in any frame accepted this cycle
  always_comb begin
    peak_l_d = peak_clr ? '0 : peak_l_q;
    peak_r_d = peak_clr ? '0 : peak_r_q;
    if (push_ok) begin
      if (abs_l > peak_l_d) peak_l_d = abs_l;
      if (abs_r > peak_r_d) peak_r_d = abs_r;
    end
  end

  // Peak registers
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      peak_l_q <= '0;
      peak_r_q <= '0;
    end else begin
      peak_l_q <= peak_l_d;
      peak_r_q <= peak_r_d;
    end
  end

  assign peak_left  = peak_l_q;
  assign peak_right = peak_r_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_left       = '0;
  assign peak_right      = '0;
`endif
endmodule

// File: tb/tb_audio_i2s_capture.sv
// tb/tb_audio_i2s_capture.sv - directed bench with frame-level model for audio_i2s_capture
module tb_audio_i2s_capture;
  logic        clk;
  logic        reset_n;
  logic        adc_bclk, adc_lrck, adc_dat;
  logic        overflow, overflow_clr, peak_clr;
  logic [15:0] peak_left, peak_right;

  audio_i2s_capture_if #(.DATA_WIDTH(16)) src_if ();

  audio_i2s_capture #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .I2S_MODE(1)) dut (
    .clk_clk(clk), .reset_reset_n(reset_n),
    .adc_bclk(adc_bclk), .adc_lrck(adc_lrck), .adc_dat(adc_dat),
    .src(src_if.master),
    .overflow(overflow), .overflow_clr(overflow_clr),
    .peak_clr(peak_clr), .peak_left(peak_left), .peak_right(peak_right)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int pops = 0;

  // Frame-level model: expected FIFO contents in push order
  logic [31:0] exp_q[$];
  logic        exp_ovf;
  logic        last_lr, prev_bit, pend_v;
  logic [15:0] pend_l, pend_r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] exp_word(input logic [31:0] v, input int n);
    logic [31:0] t;
    if (n >= 16) t = v >> (n - 16);
    else         t = v << (16 - n);
    return t[15:0];
  endfunction

  task automatic model_push(input logic [15:0] l, input logic [15:0] r);
    if (exp_q.size() < 8) exp_q.push_back({l, r});
    else                  exp_ovf = 1'b1;
  endtask

  // One BCLK period: data and LRCK change while BCLK is low
  task automatic send_bit(input logic lr, input logic d);
    adc_bclk = 1'b0; adc_lrck = lr; adc_dat = d;
    #40;
    adc_bclk = 1'b1;
    if (!lr && last_lr) begin
      if (pend_v) model_push(pend_l, pend_r);
      pend_v = 1'b0;
    end
    last_lr = lr;
    #40;
  endtask

  // I2S slot: first bit carries the previous word's LSB
  task automatic send_slot(input logic lr, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(lr, (i == 0) ? prev_bit : v[n - i]);
    prev_bit = v[0];
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    logic synced;
    synced = last_lr;
    send_slot(1'b0, l, n);
    send_slot(1'b1, r, n);
    if (synced) begin
      pend_v = 1'b1;
      pend_l = exp_word(l, n);
      pend_r = exp_word(r, n);
    end
  endtask

  task automatic send_partial(input logic lr, input int n);
    for (int i = 0; i < n; i++) send_bit(lr, 1'($urandom_range(0, 1)));
    prev_bit = 1'($urandom_range(0, 1));
  endtask

  task automatic flush();
    send_bit(1'b0, prev_bit);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    src_if.src_ready = v;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0; pend_v = 1'b0; last_lr = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    set_ready(1'b1);
    for (int i = 0; i < 400 && !done; i++) begin
      wait_clks(1);
      if (exp_q.size() == 0 && !src_if.src_valid) done = 1'b1;
    end
    check(name, {63'd0, done}, 64'd1);
  endtask

  // Scoreboard: every DUT pop must match the model head
  always @(negedge clk) begin
    if (reset_n && src_if.src_valid && src_if.src_ready) begin
      pops++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected actual=%0h required=no_frame", src_if.src_data);
      end else begin
        check("pop_data", {32'd0, src_if.src_data}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int p0;
    adc_bclk = 0; adc_lrck = 0; adc_dat = 0;
    src_if.src_ready = 0; overflow_clr = 0; peak_clr = 0;
    last_lr = 0; prev_bit = 0; pend_v = 0; exp_ovf = 0;
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    @(negedge clk);
    check("reset_valid", {63'd0, src_if.src_valid}, 64'd0);
    check("reset_data", {32'd0, src_if.src_data}, 64'd0);
    check("reset_overflow", {63'd0, overflow}, 64'd0);
    check("reset_peaks", {32'd0, peak_left, peak_right}, 64'd0);
    #1;

    // Basic frame and push-to-valid latency
    send_partial(1'b1, 5);
    send_frame(32'h1234, 32'hABCD, 16);
    adc_bclk = 1'b0; adc_lrck = 1'b0; adc_dat = prev_bit;
    #40;
    adc_bclk = 1'b1;
    if (pend_v) model_push(pend_l, pend_r);
    pend_v = 1'b0; last_lr = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("t1_valid_before_push", {63'd0, src_if.src_valid}, 64'd0);
    @(posedge clk);
    #1 check("t1_valid_latency", {63'd0, src_if.src_valid}, 64'd1);
    check("t1_data", {32'd0, src_if.src_data}, 64'h1234ABCD);
    #30;
    drain("t1_drain");

    // Overflow with 9 frames held back
    do_reset();
    src_if.src_ready = 1'b0;
    send_partial(1'b1, 3);
    for (int i = 1; i <= 9; i++)
      send_frame(32'(16'(i * 16'h1111) ^ 16'h0F0F), 32'(16'(i * 16'h0123)), 16);
    flush();
    wait_clks(8);
    check("t2_overflow", {63'd0, overflow}, 64'd1);
    check("t2_overflow_model", {63'd0, overflow}, {63'd0, exp_ovf});
    check("t2_head", {32'd0, src_if.src_data}, 64'h1E1E0123);
    @(posedge clk); #1 overflow_clr = 1'b1;
    @(posedge clk); #1 overflow_clr = 1'b0;
    check("t2_overflow_clr", {63'd0, overflow}, 64'd0);
    p0 = pops;
    drain("t2_drain");
    check("t2_pop_count", 64'(pops - p0), 64'd8);

    // Stream begins mid-word after reset
    do_reset();
    src_if.src_ready = 1'b0;
    send_partial(1'b0, 5);
    send_partial(1'b1, 16);
    send_frame(32'h5A5A, 32'hA5A5, 16);
    send_frame(32'h0001, 32'hFFFF, 16);
    flush();
    wait_clks(8);
    check("t3_first_frame", {32'd0, src_if.src_data}, 64'h5A5AA5A5);
    p0 = pops;
    drain("t3_drain");
    check("t3_pop_count", 64'(pops - p0), 64'd2);

    // Long and short slots
    do_reset();
    src_if.src_ready = 1'b0;
    send_partial(1'b1, 4);
    send_frame(32'h89ABCDEF, 32'h12345678, 32);
    flush();
    wait_clks(8);
    check("t4_slot32", {32'd0, src_if.src_data}, 64'h89AB1234);
    drain("t4_drain32");
    do_reset();
    src_if.src_ready = 1'b0;
    send_partial(1'b1, 4);
    send_frame(32'hABC, 32'h123, 12);
    flush();
    wait_clks(8);
    check("t4_slot12", {32'd0, src_if.src_data}, 64'hABC01230);
    drain("t4_drain12");

    // Reset mid-left word with frames queued
    do_reset();
    src_if.src_ready = 1'b0;
    send_partial(1'b1, 2);
    for (int i = 0; i < 3; i++) send_frame(32'(16'h0100 + i), 32'(16'h0200 + i), 16);
    flush();
    send_partial(1'b0, 4);
    check("t5_valid_before_reset", {63'd0, src_if.src_valid}, 64'd1);
    do_reset();
    @(negedge clk);
    check("t5_valid_after_reset", {63'd0, src_if.src_valid}, 64'd0);
    #1;
    send_partial(1'b0, 6);
    send_partial(1'b1, 16);
    send_frame(32'hCAFE, 32'hBEEF, 16);
    flush();
    wait_clks(8);
    check("t5_next_frame", {32'd0, src_if.src_data}, 64'hCAFEBEEF);
    drain("t5_drain");

    // Peak meter
    do_reset();
    src_if.src_ready = 1'b1;
    send_partial(1'b1, 3);
    send_frame(32'h0100, 32'h0050, 16);
    send_frame(32'h8000, 32'hFFF0, 16);
    flush();
    drain("t6_drain");
`ifdef PEAK_METER_EN
    check("t6_peak_left", {48'd0, peak_left}, 64'h7FFF);
    check("t6_peak_right", {48'd0, peak_right}, 64'h0050);
    @(posedge clk); #1 peak_clr = 1'b1;
    @(posedge clk); #1 peak_clr = 1'b0;
    check("t6_peak_clr", {32'd0, peak_left, peak_right}, 64'd0);
`else
    check("t6_peaks_tied", {32'd0, peak_left, peak_right}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
